// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and seed constants for the integer-sequence stream generator.
//   seq_mode_t  : sequence select (3 bits)
//   seq_state_t : run-control FSM state
//   seq_seed_t  : initial term history (a = term 0, b/c = older history)
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned SEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SQR  = 3'd0,
    EXP3 = 3'd1,
    TRI  = 3'd2,
    FIB  = 3'd3,
    PELL = 3'd4,
    LUC  = 3'd5,
    PAD  = 3'd6,
    SYLV = 3'd7
  } seq_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [SEED_W-1:0] a;
    logic [SEED_W-1:0] b;
    logic [SEED_W-1:0] c;
  } seq_seed_t;

  // Seeds are tiny, so they fit any WIDTH >= 2 and are zero-extended by the
  // engine. History is chosen so the uniform recurrence reproduces term 1+.
  function automatic seq_seed_t seq_seed(input seq_mode_t m);
    seq_seed_t s;
    s = '0;
    case (m)
      SQR:  s = '{a: 2'd0, b: 2'd0, c: 2'd0};
      EXP3: s = '{a: 2'd1, b: 2'd0, c: 2'd0};
      TRI:  s = '{a: 2'd0, b: 2'd0, c: 2'd0};
      FIB:  s = '{a: 2'd1, b: 2'd0, c: 2'd0};
      PELL: s = '{a: 2'd0, b: 2'd1, c: 2'd0};
      LUC:  s = '{a: 2'd2, b: 2'd0, c: 2'd0};
      PAD:  s = '{a: 2'd1, b: 2'd0, c: 2'd1};
      SYLV: s = '{a: 2'd2, b: 2'd0, c: 2'd0};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_term_engine.sv
// ---------------------------------------------------------------------------
// seq_term_engine
// Shared recurrence datapath: three-deep term history plus n counter.
//   clk, reset  : clock, synchronous active-high reset
//   i_load      : load seed history for i_mode (also latches the mode)
//   i_mode      : sequence select, used only with i_load
//   i_advance   : step the recurrence by one term
//   o_term      : current term (registered)
//   o_wrap      : combinational; next term exceeds WIDTH bits
// ---------------------------------------------------------------------------
module seq_term_engine
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_advance,
  output logic [WIDTH-1:0]  o_term,
  output logic              o_wrap
);

  localparam int unsigned FW = 2 * WIDTH + 2;

  seq_mode_t        r_mode;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_n;
  seq_seed_t        w_seed;
  logic [FW-1:0]    w_a, w_b, w_c, w_n1, w_next;

  assign w_seed = seq_seed(seq_mode_t'(i_mode));

  // Next term at full precision from the stored (already wrapped) history.
  always_comb begin
    w_a    = FW'(r_a);
    w_b    = FW'(r_b);
    w_c    = FW'(r_c);
    w_n1   = FW'(r_n) + FW'(1);
    w_next = '0;
    case (r_mode)
      SQR:  w_next = w_n1 * w_n1;
      EXP3: w_next = w_a * FW'(3);
      TRI:  w_next = w_a + w_n1;
      FIB:  w_next = w_a + w_b;
      PELL: w_next = (w_a << 1) + w_b;
      // Lucas 2,1 cannot come from a non-negative a+b, so term 1 is forced.
      LUC:  w_next = (r_n == '0) ? FW'(1) : (w_a + w_b);
      PAD:  w_next = w_b + w_c;
      // a*a >= a for any a, so this never underflows.
      SYLV: w_next = w_a * w_a - w_a + FW'(1);
      default: w_next = '0;
    endcase
  end

  assign o_wrap = |w_next[FW-1:WIDTH];
  assign o_term = r_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= SQR;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_n    <= '0;
    end else if (i_load) begin
      r_mode <= seq_mode_t'(i_mode);
      r_a    <= WIDTH'(w_seed.a);
      r_b    <= WIDTH'(w_seed.b);
      r_c    <= WIDTH'(w_seed.c);
      r_n    <= '0;
    end else if (i_advance) begin
      r_a    <= w_next[WIDTH-1:0];
      r_b    <= r_a;
      r_c    <= r_b;
      r_n    <= r_n + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_stream_gen.sv
// ---------------------------------------------------------------------------
// seq_stream_gen
// Streams len consecutive terms of a selectable integer sequence over a
// valid/ready handshake, with index, last marking and a sticky overflow flag.
//   clk, reset          : clock, synchronous active-high reset
//   i_start/o_start_ready: run request, accepted in IDLE
//   i_mode, i_len       : sequence select and term count, sampled on accept
//   i_abort             : terminate the current run
//   o_out_valid/i_out_ready, o_out_data, o_out_index, o_out_last : term stream
//   o_done              : one-cycle pulse after the final handshake
//   o_overflow          : sticky, some presented term of this run wrapped
// ---------------------------------------------------------------------------
module seq_stream_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_start_ready,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_out_data,
  output logic [LEN_W-1:0]  o_out_index,
  output logic              o_out_last,
  output logic              o_done,
  output logic              o_overflow
);

  seq_state_t       r_state;
  logic             r_start_ready;
  logic             r_valid;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_index;
  logic             r_last;
  logic             r_done;
  logic             r_overflow;

  logic             w_accept;
  logic             w_hs;
  logic             w_advance;
  logic             w_wrap;
  logic [LEN_W-1:0] w_index_nxt;

  // Abort outranks both a new start and an in-flight handshake.
  assign w_accept    = (r_state == IDLE) && i_start && !i_abort;
  assign w_hs        = r_valid && i_out_ready;
  assign w_advance   = w_hs && !r_last && !i_abort;
  assign w_index_nxt = r_index + LEN_W'(1);

  seq_term_engine #(.WIDTH(WIDTH)) u_engine (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_mode    (i_mode),
    .i_advance (w_advance),
    .o_term    (o_out_data),
    .o_wrap    (w_wrap)
  );

  // Run-control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_start_ready <= 1'b1;
      r_valid       <= 1'b0;
      r_len         <= '0;
      r_index       <= '0;
      r_last        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state       <= IDLE;
        r_start_ready <= 1'b1;
        r_valid       <= 1'b0;
        r_last        <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_len         <= i_len;
              r_index       <= '0;
              r_overflow    <= 1'b0;
              r_start_ready <= 1'b0;
              if (i_len == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= RUN;
                r_valid <= 1'b1;
                r_last  <= (i_len == LEN_W'(1));
              end
            end
          end
          RUN: begin
            if (w_hs) begin
              if (r_last) begin
                r_state <= DONE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_index    <= w_index_nxt;
                r_last     <= (w_index_nxt == r_len - LEN_W'(1));
                r_overflow <= r_overflow | w_wrap;
              end
            end
          end
          DONE: begin
            r_state       <= IDLE;
            r_start_ready <= 1'b1;
          end
          default: begin
            r_state       <= IDLE;
            r_start_ready <= 1'b1;
            r_valid       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_out_valid   = r_valid;
  assign o_out_index   = r_index;
  assign o_out_last    = r_last;
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_seq_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_stream_gen
// Directed runs push hand-computed terms into a scoreboard queue; a monitor
// compares every presented term (stalled or accepted) against the queue head.
// ---------------------------------------------------------------------------
module tb_seq_stream_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             reset;
  logic             i_start;
  logic             o_start_ready;
  logic [2:0]       i_mode;
  logic [LEN_W-1:0] i_len;
  logic             i_abort;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [WIDTH-1:0] o_out_data;
  logic [LEN_W-1:0] o_out_index;
  logic             o_out_last;
  logic             o_done;
  logic             o_overflow;

  seq_stream_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .o_start_ready (o_start_ready),
    .i_mode        (i_mode),
    .i_len         (i_len),
    .i_abort       (i_abort),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_index   (o_out_index),
    .o_out_last    (o_out_last),
    .o_done        (o_done),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int idx;
    bit last;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   tv[$];
  int   n_checks;
  int   n_fail;
  bit   toggle_ready;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare each presented term with the queue head; pop on handshake.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (o_out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_term: got data %0d index %0d, expected no term",
                   o_out_data, o_out_index);
        end else begin
          check("term_data",     int'(o_out_data),  q[0].d);
          check("term_index",    int'(o_out_index), q[0].idx);
          check("term_last",     int'(o_out_last),  int'(q[0].last));
          check("term_overflow", int'(o_overflow),  int'(q[0].ovf));
          if (i_out_ready) void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      i_out_ready = toggle_ready ? ~i_out_ready : 1'b1;
    end
  endtask

  task automatic push_run(input int n, input int len, input int ovf_from);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = tv[i];
      e.idx  = i;
      e.last = (i == len - 1);
      e.ovf  = (ovf_from >= 0) && (i >= ovf_from);
      q.push_back(e);
    end
  endtask

  // Leaves the caller 1 time unit into cycle t+1 (t = accept edge).
  task automatic start_run(input int mode, input int len);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_mode  = 3'(mode);
    i_len   = LEN_W'(len);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // exp_c: cycle after the accept edge in which done must pulse (0 = any).
  task automatic wait_done(input int exp_c, input bit exp_v1);
    bit seen;
    int found_c;
    seen    = 1'b0;
    found_c = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) check("valid_after_start", int'(o_out_valid), int'(exp_v1));
      if (o_done) begin
        seen    = 1'b1;
        found_c = c;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    else if (exp_c > 0) check("done_cycle", found_c, exp_c);
    check("valid_in_done", int'(o_out_valid), 0);
    @(negedge clk);
    check("start_ready_after_done", int'(o_start_ready), 1);
    check("done_pulse_width", int'(o_done), 0);
    check("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    reset        = 1'b1;
    i_start      = 1'b0;
    i_mode       = 3'd0;
    i_len        = '0;
    i_abort      = 1'b0;
    i_out_ready  = 1'b1;
    toggle_ready = 1'b0;
    n_checks     = 0;
    n_fail       = 0;

    fork
      monitor();
      ready_drv();
    join_none

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_start_ready", int'(o_start_ready), 1);
    check("rst_valid",       int'(o_out_valid),   0);
    check("rst_data",        int'(o_out_data),    0);
    check("rst_index",       int'(o_out_index),   0);
    check("rst_last",        int'(o_out_last),    0);
    check("rst_done",        int'(o_done),        0);
    check("rst_overflow",    int'(o_overflow),    0);

    // FIB len 6, full throughput
    tv = '{1, 1, 2, 3, 5, 8};
    push_run(6, 6, -1);
    start_run(3, 6);
    wait_done(7, 1'b1);
    check("fib_overflow", int'(o_overflow), 0);

    // PAD len 10 with ready toggling every cycle
    tv = '{1, 1, 1, 2, 2, 3, 4, 5, 7, 9};
    push_run(10, 10, -1);
    toggle_ready = 1'b1;
    start_run(6, 10);
    wait_done(0, 1'b1);
    toggle_ready = 1'b0;

    // SYLV len 5: 1807 wraps to 15, flag sticky past done
    tv = '{2, 3, 7, 43, 15};
    push_run(5, 5, 4);
    start_run(7, 5);
    wait_done(6, 1'b1);
    check("sylv_overflow_sticky", int'(o_overflow), 1);

    // EXP3 len 7: 729 wraps to 217 on the last term
    tv = '{1, 3, 9, 27, 81, 243, 217};
    push_run(7, 7, 6);
    start_run(1, 7);
    wait_done(8, 1'b1);
    check("exp3_overflow", int'(o_overflow), 1);

    // PELL len 4, abort coincident with the index-2 handshake
    tv = '{0, 1, 2};
    push_run(3, 4, -1);
    start_run(4, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_valid",       int'(o_out_valid),   0);
    check("abort_start_ready", int'(o_start_ready), 1);
    check("abort_done",        int'(o_done),        0);
    check("abort_overflow",    int'(o_overflow),    0);
    check("abort_drained",     q.size(),            0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(o_done), 0);
    end

    // len 0: done in t+1, no terms
    start_run(3, 0);
    wait_done(1, 1'b0);

    // LUC len 5
    tv = '{2, 1, 3, 4, 7};
    push_run(5, 5, -1);
    start_run(5, 5);
    wait_done(6, 1'b1);

    // TRI len 5 with a start (and mode/len change) injected mid-run
    tv = '{0, 1, 3, 6, 10};
    push_run(5, 5, -1);
    start_run(2, 5);
    fork
      wait_done(6, 1'b1);
      begin
        @(posedge clk); #1;
        i_start = 1'b1;
        i_mode  = 3'd0;
        i_len   = LEN_W'(2);
        @(posedge clk); #1;
        i_start = 1'b0;
      end
    join

    // TRI len 8, reset while index 3 is presented
    tv = '{0, 1, 3, 6};
    push_run(4, 8, -1);
    start_run(2, 8);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_start_ready", int'(o_start_ready), 1);
    check("mrst_valid",       int'(o_out_valid),   0);
    check("mrst_data",        int'(o_out_data),    0);
    check("mrst_index",       int'(o_out_index),   0);
    check("mrst_last",        int'(o_out_last),    0);
    check("mrst_done",        int'(o_done),        0);
    check("mrst_overflow",    int'(o_overflow),    0);
    check("mrst_drained",     q.size(),            0);

    // SQR len 4 after reset
    tv = '{0, 1, 4, 9};
    push_run(4, 4, -1);
    start_run(0, 4);
    wait_done(5, 1'b1);
    check("sqr_overflow", int'(o_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_stream_gen.md
# seq_stream_gen

Parametrised integer-sequence generator that streams a run of `len` consecutive terms of one of eight selectable sequences over a valid/ready handshake. It replaces the free-running fixed 8-bit per-sequence generators with a single shared datapath. Run length, term index, last-term marking, back-pressure and a sticky overflow flag are added. It sits between the top-level input decode and the output mux / any downstream consumer.

## Interface
- `WIDTH`, 8: term width; all arithmetic is modulo 2^WIDTH.
- `LEN_W`, 8: width of `len` and `out_index`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a run; accepted only when `start_ready`=1.
- `start_ready`  out  1  high in IDLE.
- `mode`  in  3  sequence select, sampled on start acceptance.
- `len`  in  LEN_W  number of terms, sampled on start acceptance.
- `abort`  in  1  terminate the current run.
- `out_valid`  out  1  `out_data` holds a term.
- `out_ready`  in  1  consumer accepts the term.
- `out_data`  out  WIDTH  current term.
- `out_index`  out  LEN_W  0-based term index.
- `out_last`  out  1  current term is index `len`-1.
- `done`  out  1  one-cycle pulse after the final handshake.
- `overflow`  out  1  sticky: some term of this run wrapped.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: on `start` with `len`≠0.
  - IDLE→DONE: on `start` with `len`=0; no terms are emitted.
  - RUN→DONE: on the handshake with `out_last`=1.
  - DONE→IDLE: always, after one cycle.
  - Any state→IDLE: on `abort`.
- On start acceptance:
  - Latch `mode` and `len`.
  - Clear `overflow`.
  - Load the seed state for the selected mode.
- A handshake (`out_valid`&&`out_ready`) advances the recurrence by one term and increments `out_index`.
- Modes, first terms from index 0:
  - 0 SQR: n², 0,1,4,9.
  - 1 EXP3: ×3, 1,3,9,27,81,243,217.
  - 2 TRI: +n, 0,1,3,6,10.
  - 3 FIB: 1,1,2,3,5.
  - 4 PELL: a=2b+c, 0,1,2,5,12,29,70,169,152.
  - 5 LUC: 2,1,3,4,7.
  - 6 PAD: a(n)=a(n-2)+a(n-3), 1,1,1,2,2,3,4,5,7,9.
  - 7 SYLV: a=b(b-1)+1, 2,3,7,43,15.
- Overflow:
  - Each next term is computed at full precision (2·WIDTH+2 bits) from the stored, already-wrapped operands.
  - `overflow` sets when that result is ≥2^WIDTH.
  - It holds until the next start acceptance or reset.
- `abort` has priority over a simultaneous handshake: no `done`, `out_valid` drops, `overflow` holds its value.
- `start` is ignored when `start_ready`=0.
- `mode`/`len` changes mid-run have no effect.

## Timing
- Reset values:
  - State IDLE; `start_ready`=1.
  - `out_valid`, `out_data`, `out_index`, `out_last`, `done` and `overflow` all 0.
- Start accepted at edge t: `out_valid`=1 with term 0 from cycle t+1.
- Handshake at cycle k, not last: term k+1 is presented in cycle k+1, giving full throughput of one term per cycle under constant `out_ready`.
- While `out_valid`&&!`out_ready`, `out_data`, `out_index` and `out_last` hold stable.
- Last handshake at cycle k:
  - Cycle k+1: DONE, `out_valid`=0, `done`=1.
  - Cycle k+2: IDLE, `start_ready`=1.
- `len`=0: `done` in cycle t+1.
- `overflow` is registered and asserts in the cycle the wrapped term is presented on `out_data`.
- `abort` at cycle k: IDLE in k+1.
- `reset` overrides everything, including `abort` and `start`.

## Structure
- Package `seq_pkg`:
  - `seq_mode_t` enum: SQR, EXP3, TRI, FIB, PELL, LUC, PAD, SYLV.
  - `seq_state_t` enum: IDLE, RUN, DONE.
  - Per-mode seed constants as functions of WIDTH.
- Sub-module `seq_term_engine`:
  - Holds the three-deep term history and the n counter.
  - Inputs: `load`, `mode`, `advance`.
  - Outputs: `term`, `wrap`.
  - The top level holds the FSM, handshake, index/last logic and overflow flag.

## Test plan
- FIB, `len`=6, `out_ready`=1 → 1,1,2,3,5,8 on consecutive cycles; `out_last` on index 5; `done` one cycle later; `overflow`=0.
- PAD, `len`=10, `out_ready` toggled every cycle → 1,1,1,2,2,3,4,5,7,9 with data held while stalled.
- SYLV, `len`=5 → 2,3,7,43,15; `overflow` rises with 15 and stays 1 after `done`. EXP3, `len`=7 → 217 last, `overflow`=1.
- PELL, `len`=4, `abort` asserted coincident with the index-2 handshake → IDLE next cycle, no `done`, no index 3.
- `len`=0 → `done` in cycle t+1 and no `out_valid`. `start` asserted during RUN → ignored and the run completes unchanged.
- `reset` mid-run (TRI, index 3) → all outputs 0 and IDLE next cycle. A new SQR run then yields 0,1,4,9 with `overflow` cleared.
